// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris keypad front end: key bit positions,
// per-key state encoding and counter sizing helpers.
package tetris_pkg;

    localparam int NUM_KEYS  = 4;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_DELAY  = 2'd1,
        KEY_REPEAT = 2'd2
    } key_state_t;

    // Bits needed to hold the values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_ctrl_if.sv
// Keypad bundle between the raw buttons/consumer (master) and key_ctrl (slave).
interface key_ctrl_if;
    import tetris_pkg::*;

    logic [NUM_KEYS-1:0] key_raw;
    logic                key_ack;
    logic [NUM_KEYS-1:0] op_keys;
    logic [NUM_KEYS-1:0] key_level;

    modport master (
        output key_raw,
        output key_ack,
        input  op_keys,
        input  key_level
    );

    modport slave (
        input  key_raw,
        input  key_ack,
        output op_keys,
        output key_level
    );

endinterface

// File: rtl/key_debounce.sv
// One button: two-flop synchronizer followed by a stable-time debouncer.
// The debounced level only moves once the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts
// the count. A DEBOUNCE_CYCLES below 1 behaves like 1.
module key_debounce
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic vga_clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level
);

    localparam int DB_W        = cnt_width(DEBOUNCE_CYCLES);
    localparam int DB_LAST_INT = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LAST_INT);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            level_q;

    // Bring the asynchronous button into the vga_clk domain.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    // Count consecutive disagreeing cycles; flip the level on the last one.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else if (sync_q[1] != level_q) begin
            if (db_cnt_q >= DB_LAST) begin
                level_q  <= sync_q[1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/key_ctrl.sv
// Keypad controller: four debounced buttons, a press/auto-repeat FSM per key
// and a sticky event register that the consumer clears with key_ack.
// Optional feature macro: KEY_CTRL_AUTOREPEAT_EN enables auto-repeat
// (first repeat REPEAT_DELAY cycles after the press, then every
// REPEAT_RATE cycles). Without it each debounced press yields one event.
module key_ctrl
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic       vga_clk,
    input  logic       rst,
    key_ctrl_if.slave  bus
);

    logic [NUM_KEYS-1:0] level_w;
    logic [NUM_KEYS-1:0] event_w;
    logic [NUM_KEYS-1:0] rpt_due_w;
    logic [NUM_KEYS-1:0] op_q;
    key_state_t          state_q [NUM_KEYS];

    // Reject timing parameters that would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_ctrl: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .vga_clk   (vga_clk),
            .rst       (rst),
            .key_raw   (bus.key_raw[k]),
            .key_level (level_w[k])
        );
    end

`ifdef KEY_CTRL_AUTOREPEAT_EN
    localparam int RPT_W          = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam int DELAY_LAST_INT = (REPEAT_DELAY > 1) ? REPEAT_DELAY - 1 : 0;
    localparam int RATE_LAST_INT  = (REPEAT_RATE > 1) ? REPEAT_RATE - 1 : 0;
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(DELAY_LAST_INT);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(RATE_LAST_INT);

    logic [RPT_W-1:0] rpt_cnt_q [NUM_KEYS];

    // A repeat falls due on the last cycle of the current DELAY/REPEAT interval.
    always_comb begin
        rpt_due_w = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            case (state_q[i])
                KEY_DELAY:  rpt_due_w[i] = (rpt_cnt_q[i] >= DELAY_LAST);
                KEY_REPEAT: rpt_due_w[i] = (rpt_cnt_q[i] >= RATE_LAST);
                default:    rpt_due_w[i] = 1'b0;
            endcase
        end
    end

    // Interval counters: restart on every event, clear when idle or released, saturate otherwise.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (state_q[i] == KEY_IDLE || !level_w[i] || rpt_due_w[i]) begin
                    rpt_cnt_q[i] <= '0;
                end else if (rpt_cnt_q[i] != '1) begin
                    rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_W'(1);
                end
            end
        end
    end
`else
    assign rpt_due_w = '0;
`endif

    // Events: the press itself from IDLE, and due repeats while still held.
    always_comb begin
        event_w = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            case (state_q[i])
                KEY_IDLE:   event_w[i] = level_w[i];
                KEY_DELAY,
                KEY_REPEAT: event_w[i] = level_w[i] & rpt_due_w[i];
                default:    event_w[i] = 1'b0;
            endcase
        end
    end

    // Per-key FSMs and the sticky event register; a same-cycle event beats key_ack.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= KEY_IDLE;
            end
            op_q <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                case (state_q[i])
                    KEY_IDLE: begin
                        if (level_w[i]) begin
                            state_q[i] <= KEY_DELAY;
                        end
                    end
                    KEY_DELAY: begin
                        if (!level_w[i]) begin
                            state_q[i] <= KEY_IDLE;
                        end else if (rpt_due_w[i]) begin
                            state_q[i] <= KEY_REPEAT;
                        end
                    end
                    KEY_REPEAT: begin
                        if (!level_w[i]) begin
                            state_q[i] <= KEY_IDLE;
                        end
                    end
                    default: state_q[i] <= KEY_IDLE;
                endcase
            end
            op_q <= (op_q & ~{NUM_KEYS{bus.key_ack}}) | event_w;
        end
    end

    assign bus.op_keys   = op_q;
    assign bus.key_level = level_w;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. Expected results follow KEY_CTRL_AUTOREPEAT_EN when defined.
module tb_key_ctrl;
    import tetris_pkg::*;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    localparam logic [3:0] M_UP    = 4'(1 << KEY_UP);
    localparam logic [3:0] M_DOWN  = 4'(1 << KEY_DOWN);
    localparam logic [3:0] M_LEFT  = 4'(1 << KEY_LEFT);
    localparam logic [3:0] M_RIGHT = 4'(1 << KEY_RIGHT);

    typedef struct {
        logic [3:0] raw;
        logic       ack;
        logic [3:0] exp_op;
        logic [3:0] exp_level;
    } vec_t;

    logic vga_clk = 1'b0;
    logic rst;
    int   checks_total  = 0;
    int   checks_passed = 0;

    key_ctrl_if bus();

    key_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .bus     (bus)
    );

    // 25 MHz-style free-running clock
    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic ack);
        bus.key_raw = raw;
        bus.key_ack = ack;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        vec_t       press_vecs [19];
        logic [3:0] bounce_op_or;
        logic       bounce_lvl_or;
        int         rises [$];
        int         exp_rises [$];
        logic [3:0] raw_now;

        // Clean press of LEFT held 10 cycles, release, then one ack.
        for (int i = 0; i < 10; i++) begin
            press_vecs[i] = '{raw: M_LEFT, ack: 1'b0,
                              exp_op: (i >= 6) ? M_LEFT : 4'b0000,
                              exp_level: (i >= 5) ? M_LEFT : 4'b0000};
        end
        for (int i = 10; i < 17; i++) begin
            press_vecs[i] = '{raw: 4'b0000, ack: 1'b0, exp_op: M_LEFT,
                              exp_level: (i >= 15) ? 4'b0000 : M_LEFT};
        end
        press_vecs[17] = '{raw: 4'b0000, ack: 1'b1, exp_op: 4'b0000, exp_level: 4'b0000};
        press_vecs[18] = '{raw: 4'b0000, ack: 1'b0, exp_op: 4'b0000, exp_level: 4'b0000};

        // Reset state
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        #12;
        checkOutput("reset op_keys", 32'(bus.op_keys), 32'h0);
        checkOutput("reset key_level", 32'(bus.key_level), 32'h0);
        tick();
        rst = 1'b0;

        // Bounce: UP toggling every 2 cycles must never debounce
        bounce_op_or  = '0;
        bounce_lvl_or = 1'b0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(((c / 2) % 2 == 1) ? M_UP : 4'b0000, 1'b0);
            tick();
            bounce_op_or  = bounce_op_or | bus.op_keys;
            bounce_lvl_or = bounce_lvl_or | bus.key_level[KEY_UP];
        end
        checkOutput("bounce key_level[0]", 32'(bounce_lvl_or), 32'h0);
        checkOutput("bounce op_keys", 32'(bounce_op_or), 32'h0);
        applyStimulus(4'b0000, 1'b0);
        repeat (10) tick();

        // Table-driven clean press
        for (int i = 0; i < 19; i++) begin
            applyStimulus(press_vecs[i].raw, press_vecs[i].ack);
            tick();
            checkOutput($sformatf("press[%0d] op_keys", i), 32'(bus.op_keys), 32'(press_vecs[i].exp_op));
            checkOutput($sformatf("press[%0d] key_level", i), 32'(bus.key_level), 32'(press_vecs[i].exp_level));
        end

        // Ack race: LEFT pending, DOWN event coincides with key_ack
        applyStimulus(M_LEFT, 1'b0);
        repeat (8) tick();
        applyStimulus(4'b0000, 1'b0);
        repeat (8) tick();
        checkOutput("race setup op_keys", 32'(bus.op_keys), 32'(M_LEFT));
        applyStimulus(M_DOWN, 1'b0);
        repeat (6) tick();
        checkOutput("race pre-event op_keys", 32'(bus.op_keys), 32'(M_LEFT));
        applyStimulus(M_DOWN, 1'b1);
        tick();
        checkOutput("race event wins over ack", 32'(bus.op_keys), 32'(M_DOWN));
        applyStimulus(M_DOWN, 1'b0);
        tick();
        checkOutput("race bit held", 32'(bus.op_keys), 32'(M_DOWN));
        applyStimulus(4'b0000, 1'b1);
        tick();
        applyStimulus(4'b0000, 1'b0);
        repeat (10) tick();

        // Simultaneous UP and RIGHT presses both latch
        applyStimulus(M_UP | M_RIGHT, 1'b0);
        repeat (7) tick();
        checkOutput("simultaneous op_keys", 32'(bus.op_keys), 32'(M_UP | M_RIGHT));
        checkOutput("simultaneous key_level", 32'(bus.key_level), 32'(M_UP | M_RIGHT));
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("simultaneous ack clears", 32'(bus.op_keys), 32'h0);
        applyStimulus(4'b0000, 1'b0);
        repeat (10) tick();

        // RIGHT held 60 cycles, acked after each observed event
`ifdef KEY_CTRL_AUTOREPEAT_EN
        exp_rises = '{7, 27, 35, 43, 51, 59};
`else
        exp_rises = '{7};
`endif
        applyStimulus(M_RIGHT, 1'b0);
        for (int cyc = 1; cyc <= 110; cyc++) begin
            tick();
            if (bus.op_keys[KEY_RIGHT]) begin
                rises.push_back(cyc);
            end
            raw_now = (cyc < 60) ? M_RIGHT : 4'b0000;
            applyStimulus(raw_now, bus.op_keys[KEY_RIGHT]);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("repeat event count", 32'(rises.size()), 32'(exp_rises.size()));
        for (int i = 0; i < exp_rises.size(); i++) begin
            checkOutput($sformatf("repeat event %0d cycle", i),
                        (i < rises.size()) ? 32'(rises[i]) : 32'hFFFF_FFFF, 32'(exp_rises[i]));
        end
        repeat (4) tick();

        // Reset while UP is held deep into its repeat phase
        applyStimulus(M_UP, 1'b0);
        repeat (34) tick();
        checkOutput("pre-reset op_keys", 32'(bus.op_keys), 32'(M_UP));
        checkOutput("pre-reset key_level", 32'(bus.key_level), 32'(M_UP));
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset op_keys", 32'(bus.op_keys), 32'h0);
        checkOutput("async reset key_level", 32'(bus.key_level), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        checkOutput("post-reset no early event", 32'(bus.op_keys), 32'h0);
        checkOutput("post-reset level up", 32'(bus.key_level), 32'(M_UP));
        tick();
        checkOutput("post-reset event", 32'(bus.op_keys), 32'(M_UP));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
